map_bank: RTL

Multi-channel bit-map store for the game board: holds CHANNELS independent MAP_BITS-wide maps (mine, flag, step and cursor position at the default size) and presents them in parallel to the board renderer. It generalises the per-map serial loader. All state runs on the system clock rather than on key-derived clocks. The block synchronises and edge-detects the raw key strobe internally, tracks fill level per channel and rejects overfill. It also supports single-bit addressed writes and per-channel clear for game logic.

---
 rtl/map_bank_if.sv | 29 ++
 rtl/map_bank.sv | 75 +++++++
 2 files changed

// File: rtl/map_bank_if.sv
// map_bank_if: control/data bundle between game logic and the map bank.
interface map_bank_if #(
  parameter int CHANNELS = 4,
  parameter int MAP_BITS = 64
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam int ADDR_W = $clog2(MAP_BITS);
  localparam int CNT_W = $clog2(MAP_BITS + 1);
  logic [SEL_W-1:0] sel;
  logic shift_req;
  logic shift_d;
  logic clear_req;
  logic bit_we;
  logic [SEL_W-1:0] bit_ch;
  logic [ADDR_W-1:0] bit_addr;
  logic bit_val;
  logic [CHANNELS*MAP_BITS-1:0] maps;
  logic [CHANNELS-1:0] full;
  logic [CNT_W-1:0] fill;
  logic ovf;
  modport master (
    output sel, shift_req, shift_d, clear_req, bit_we, bit_ch, bit_addr, bit_val,
    input maps, full, fill, ovf
  );
  modport slave (
    input sel, shift_req, shift_d, clear_req, bit_we, bit_ch, bit_addr, bit_val,
    output maps, full, fill, ovf
  );
endinterface

// File: rtl/map_bank.sv
// map_bank: multi-channel bit-map store with synchronised serial loader, addressed writes and clears.
module map_bank #(
  parameter int CHANNELS = 4,
  parameter int MAP_BITS = 64
) (
  input logic clk,
  input logic resetn,
  map_bank_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam int CNT_W = $clog2(MAP_BITS + 1);
  logic [MAP_BITS-1:0] map_q [CHANNELS];
  logic [MAP_BITS-1:0] map_d [CHANNELS];
  logic [CNT_W-1:0] cnt_q [CHANNELS];
  logic [CNT_W-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0] full_q, full_d;
  logic ovf_q, ovf_d;
  logic s1_q, s2_q, s3_q, d1_q, d2_q, prim_q, arm_q;
  logic pulse;
  // arm_q stays low until a real low key level reaches s1, so a key still held
  // through reset release cannot produce a shift.
  assign pulse = s2_q & ~s3_q & arm_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int c = 0; c < CHANNELS; c++) begin
        map_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      full_q <= '0;
      ovf_q <= 1'b0;
      {s1_q, s2_q, s3_q, d1_q, d2_q, prim_q, arm_q} <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        map_q[c] <= map_d[c];
        cnt_q[c] <= cnt_d[c];
      end
      full_q <= full_d;
      ovf_q <= ovf_d;
      {s1_q, s2_q, s3_q} <= {bus.shift_req, s1_q, s2_q};
      {d1_q, d2_q} <= {bus.shift_d, d1_q};
      prim_q <= 1'b1;
      arm_q <= arm_q | (prim_q & ~s1_q);
    end
  always_comb begin
    ovf_d = 1'b0;
    full_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      map_d[c] = map_q[c];
      cnt_d[c] = cnt_q[c];
      if (bus.clear_req && bus.sel == SEL_W'(c)) begin
        map_d[c] = '0;
        cnt_d[c] = '0;
      end else if (pulse && bus.sel == SEL_W'(c)) begin
        if (full_q[c])
          ovf_d = 1'b1;
        else begin
          map_d[c] = {map_q[c][MAP_BITS-2:0], d2_q};
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end else if (bus.bit_we && bus.bit_ch == SEL_W'(c) && int'(bus.bit_addr) < MAP_BITS)
        map_d[c][bus.bit_addr] = bus.bit_val;
      full_d[c] = cnt_d[c] == CNT_W'(MAP_BITS);
    end
  end
  always_comb begin
    bus.fill = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      bus.maps[c*MAP_BITS +: MAP_BITS] = map_q[c];
      if (bus.sel == SEL_W'(c))
        bus.fill = cnt_q[c];
    end
  end
  assign bus.full = full_q;
  assign bus.ovf = ovf_q;
endmodule
